// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bundle for the restoring divider.
// The master drives the request; the slave (the divider) returns status and results.
interface restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned.
// Signed operands are reduced to magnitudes at acceptance; signs are re-applied
// when results are registered in FINISH. Each trial subtraction goes through an
// 8-bit-segment carry-select adder with the divisor inverted and carry-in = 1.
module restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    restoring_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder R
    logic [WIDTH-1:0] quo_q, quo_d;          // dividend magnitude shifting into quotient Q
    logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude D
    logic [WIDTH-1:0] dvd_q, dvd_d;          // raw dividend, returned on divide by zero
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;               // s = {R, Q[MSB]}
    logic [WIDTH:0]   trial;                 // {cout, s[WIDTH-1:0] - D}

    // Carry-select adder: each byte precomputes both carry-in outcomes and the
    // incoming carry picks one, so the ripple is only across segment muxes.
    function automatic logic [WIDTH:0] csel_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
        logic             c;
        logic [8:0]       s0;
        logic [8:0]       s1;
        logic [WIDTH-1:0] sum;
        c   = cin;
        sum = '0;
        for (int i = 0; i < WIDTH / 8; i++) begin
            s0 = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
            s1 = s0 + 9'd1;
            sum[i*8 +: 8] = c ? s1[7:0] : s0[7:0];
            c = c ? s1[8] : s0[8];
        end
        return {c, sum};
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    // Trial subtraction for the current iteration.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = csel_add(shifted[WIDTH-1:0], ~dvs_q, 1'b1);
    end

    // Next-state, datapath and result logic.
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        dvd_d         = dvd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        ovf_pend_d    = ovf_pend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d         = bus.dividend;
                    quo_d         = magnitude(bus.dividend, bus.is_signed);
                    dvs_d         = magnitude(bus.divisor, bus.is_signed);
                    rem_d         = '0;
                    cnt_d         = '0;
                    neg_quo_d     = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d     = bus.is_signed && bus.dividend[WIDTH-1];
                    ovf_pend_d    = bus.is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    state_d       = (bus.divisor == '0) ? FINISH : RUN;
                end
            end

            RUN: begin
                if (shifted[WIDTH] || trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dvs_q == '0) begin
                    quotient_d    = '1;
                    remainder_d   = dvd_q;
                    div_by_zero_d = 1'b1;
                end else if (ovf_pend_q) begin
                    quotient_d  = MIN_NEG;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? ('0 - quo_q) : quo_q;
                    remainder_d = neg_rem_q ? ('0 - rem_q) : rem_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: every register, working datapath included, is reset so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dvd_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            ovf_pend_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            dvd_q         <= dvd_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            ovf_pend_q    <= ovf_pend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
        end
    end

    // Busy covers RUN and FINISH; done is registered on the exit from FINISH,
    // so the two never overlap.
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: expected results are queued at start
// and compared, with latency, whenever the divider pulses done.
module tb_restoring_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          acc;
        int          lat;
        int          id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   op_id  = 0;
    exp_t sb[$];
    exp_t mon_e;

    restoring_divider_if #(.WIDTH(32)) bus ();

    restoring_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: native SV division (truncating), plus the special cases.
    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = 33;
        e.acc = 0;
        e.id  = 0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q  = 32'h8000_0000;
            e.r  = 32'd0;
            e.ov = 1'b1;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check("busy_with_done", 32'(bus.busy), 32'd0);
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check($sformatf("op%0d_quotient", mon_e.id), bus.quotient, mon_e.q);
                check($sformatf("op%0d_remainder", mon_e.id), bus.remainder, mon_e.r);
                check($sformatf("op%0d_div_by_zero", mon_e.id), 32'(bus.div_by_zero), 32'(mon_e.dz));
                check($sformatf("op%0d_overflow", mon_e.id), 32'(bus.overflow), 32'(mon_e.ov));
                check($sformatf("op%0d_latency", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Drive a request at the current negedge, queue its expectation, then drop
    // start and scramble the operands to show they are not re-sampled.
    task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        e     = model(sgn, a, b);
        e.acc = cyc + 1;
        e.id  = op_id;
        op_id++;
        sb.push_back(e);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = ~sgn;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive_op(sgn, a, b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        check("op_timeout", 32'(sb.size() == 0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_quotient"}, bus.quotient, 32'd0);
        check({tag, "_remainder"}, bus.remainder, 32'd0);
        check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed cases
        issue(1'b0, 32'd100, 32'd7);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_quotient", bus.quotient, 32'd14);
        check("hold_remainder", bus.remainder, 32'd2);

        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_idle();
        issue(1'b0, 32'h1234_5678, 32'h0000_0000);
        wait_idle();
        issue(1'b1, 32'h8765_4321, 32'h0000_0000);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'h0000_0001);
        wait_idle();
        issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_idle();

        // Random operands, divisor widths varied by shifting
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            issue(rs, ra, rb);
            wait_idle();
        end

        // Back-to-back: start held during the done cycle is accepted
        issue(1'b0, 32'd1000, 32'd33);
        for (int i = 0; i < 50 && !bus.done; i++) @(negedge clk);
        check("b2b_done_seen", 32'(bus.done), 32'd1);
        if (bus.done) drive_op(1'b1, 32'hFFFF_FC18, 32'd33);
        wait_idle();

        // Start pulsed mid-operation with new operands is ignored
        issue(1'b0, 32'd1000, 32'd9);
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-RUN: outputs clear at once, no done follows
        issue(1'b0, 32'd5000, 32'd3);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrun_no_done_flag", 32'(bus.done), 32'd0);

        // Next operation after reset completes normally
        issue(1'b0, 32'd5000, 32'd3);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
